// File: rtl/output_config_bank.sv
// output_config_bank: double-buffered APA102 channel configuration with atomic commit
// and a timed reset pulse on every channel whose active configuration changed.
module output_config_bank #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int OUTPUT_COUNT = 10,
  parameter logic [11:0] REG_BASE = 12'hFF0,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  input  logic [DATA_BUS_WIDTH-1:0] write_data,
  input  logic write_strobe,
  input  logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic read_request,
  output logic [DATA_BUS_WIDTH-1:0] read_data,
  output logic read_valid,
  input  logic [OUTPUT_COUNT-1:0] outputs_idle,
  output logic [16*OUTPUT_COUNT-1:0] word_counts,
  output logic [16*OUTPUT_COUNT-1:0] start_addresses,
  output logic [2*OUTPUT_COUNT-1:0] clock_divisors,
  output logic [8*OUTPUT_COUNT-1:0] page_counts,
  output logic [OUTPUT_COUNT-1:0] double_pixels,
  output logic [OUTPUT_COUNT-1:0] output_resets,
  output logic busy
);
  localparam int N = OUTPUT_COUNT;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int CW = $clog2(RESET_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_IDLE, APPLY, HOLD} state_t;
  state_t state, next_state;

  logic [15:0] sh_wc [N];
  logic [15:0] sh_sa [N];
  logic [1:0] sh_cd [N];
  logic [7:0] sh_pc [N];
  logic [15:0] act_wc [N];
  logic [15:0] act_sa [N];
  logic [1:0] act_cd [N];
  logic [7:0] act_pc [N];
  logic [N-1:0] sh_dp, act_dp, manual_mask, hold_active, changed;
  logic [CW-1:0] hold_cnt;
  logic wait_idle, dirty, overrun, apply;

  logic [11:0] w_blk, r_blk;
  logic [3:0] w_off, r_off;
  logic w_chan, w_field, w_dp, w_mask, w_ctrl, commit_req, shadow_wr, status_rd;
  logic [DW-1:0] rd_val;

  // Block index wraps modulo 4096, so addresses below REG_BASE decode as far-away blocks.
  assign w_blk = write_address[15:4] - REG_BASE;
  assign r_blk = read_address[15:4] - REG_BASE;
  assign w_off = write_address[3:0];
  assign r_off = read_address[3:0];
  assign w_chan = {1'b0, w_off} < 5'(N);
  assign w_field = write_strobe && w_chan &&
                   (w_blk == 12'd0 || w_blk == 12'd1 || w_blk == 12'd3 || w_blk == 12'd4);
  assign w_dp = write_strobe && w_blk == 12'd5 && w_off == 4'd0;
  assign w_mask = write_strobe && w_blk == 12'd2 && w_off == 4'd0;
  assign w_ctrl = write_strobe && w_blk == 12'd6 && w_off == 4'd0;
  assign commit_req = w_ctrl && write_data[0];
  assign shadow_wr = w_field || w_dp;
  assign status_rd = read_request && r_blk == 12'd7 && r_off == 4'd0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;

  // The commit write also carries the wait_idle bit, so the same write decides the path.
  always_comb
    next_state = state == IDLE      ? (commit_req ? (write_data[1] ? WAIT_IDLE : APPLY) : IDLE)
               : state == WAIT_IDLE ? (&outputs_idle ? APPLY : WAIT_IDLE)
               : state == APPLY     ? (|changed ? HOLD : IDLE)
               :                      (hold_cnt == '0 ? IDLE : HOLD);

  always_comb begin
    busy = state != IDLE;
    apply = state == APPLY;
  end

  always_comb begin
    changed = '0;
    for (int i = 0; i < N; i++)
      changed[i] = sh_wc[i] != act_wc[i] || sh_sa[i] != act_sa[i] || sh_cd[i] != act_cd[i] ||
                   sh_pc[i] != act_pc[i] || sh_dp[i] != act_dp[i];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        sh_wc[i] <= '0;
        sh_sa[i] <= '0;
        sh_cd[i] <= '0;
        sh_pc[i] <= 8'd1;
      end
      sh_dp <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (w_field && w_off == 4'(i)) begin
          if (w_blk == 12'd0) sh_wc[i] <= write_data[15:0];
          if (w_blk == 12'd1) sh_sa[i] <= write_data[15:0];
          if (w_blk == 12'd3) sh_cd[i] <= write_data[1:0];
          if (w_blk == 12'd4) sh_pc[i] <= write_data[7:0];
        end
      if (w_dp) sh_dp <= write_data[N-1:0];
    end

  // APPLY samples the shadow before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        act_wc[i] <= '0;
        act_sa[i] <= '0;
        act_cd[i] <= '0;
        act_pc[i] <= 8'd1;
      end
      act_dp <= '0;
    end else if (apply) begin
      for (int i = 0; i < N; i++) begin
        act_wc[i] <= sh_wc[i];
        act_sa[i] <= sh_sa[i];
        act_cd[i] <= sh_cd[i];
        act_pc[i] <= sh_pc[i];
      end
      act_dp <= sh_dp;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      manual_mask <= '1;
      wait_idle <= 1'b0;
      dirty <= 1'b0;
      overrun <= 1'b0;
      hold_active <= '0;
      hold_cnt <= '0;
    end else begin
      if (w_mask) manual_mask <= write_data[N-1:0];
      if (w_ctrl) wait_idle <= write_data[1];
      dirty <= shadow_wr || (dirty && !apply);
      overrun <= (commit_req && busy) || (overrun && !status_rd);
      hold_active <= apply ? changed : (state == HOLD && hold_cnt == '0) ? '0 : hold_active;
      hold_cnt <= apply ? CW'(RESET_HOLD_CYCLES - 1)
                : (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
    end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N; i++)
      if (r_off == 4'(i))
        rd_val = r_blk == 12'd0 ? DW'(sh_wc[i])
               : r_blk == 12'd1 ? DW'(sh_sa[i])
               : r_blk == 12'd3 ? DW'(sh_cd[i])
               : r_blk == 12'd4 ? DW'(sh_pc[i]) : '0;
    if (r_off == 4'd0)
      rd_val = r_blk == 12'd2 ? DW'(manual_mask)
             : r_blk == 12'd5 ? DW'(sh_dp)
             : r_blk == 12'd6 ? DW'({wait_idle, 1'b0})
             : r_blk == 12'd7 ? DW'({overrun, dirty, busy}) : rd_val;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      read_valid <= 1'b0;
      read_data <= '0;
    end else begin
      read_valid <= read_request;
      if (read_request) read_data <= rd_val;
    end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign word_counts[16*g +: 16] = act_wc[g];
    assign start_addresses[16*g +: 16] = act_sa[g];
    assign clock_divisors[2*g +: 2] = act_cd[g];
    assign page_counts[8*g +: 8] = act_pc[g];
  end

  assign double_pixels = act_dp;
  assign output_resets = manual_mask | hold_active;
endmodule

// File: doc/output_config_bank.md
Name: output_config_bank

Overview:
- Parametrised, double-buffered configuration register bank for N APA102 output channels. Replaces the ad-hoc register decode in the top level.
- SPI writes land in shadow registers. A commit copies all shadow registers into the active registers atomically, optionally waiting until every output is idle.
- On commit, every channel whose active config changed gets a timed reset pulse.
- A one-cycle-latency read-back port serves the register map.

Parameters:
- ADDRESS_BUS_WIDTH, 16: width of the word address bus.
- DATA_BUS_WIDTH, 16: width of the data bus; must be ≥ 16.
- OUTPUT_COUNT, 10: number of output channels, 1..16.
- REG_BASE, 12'hFF0: value of address[15:4] for block 0. Block k is at REG_BASE+k.
- RESET_HOLD_CYCLES, 16: length of the post-commit channel reset pulse in clk cycles, ≥ 1.

Ports:
- clk  in  1  system clock (48 MHz HFOSC).
- rst  in  1  asynchronous, active-low reset.
- write_address  in  ADDRESS_BUS_WIDTH  word address from spi_in.
- write_data  in  DATA_BUS_WIDTH  write data.
- write_strobe  in  1  one-cycle write pulse.
- read_address  in  ADDRESS_BUS_WIDTH  read-back address.
- read_request  in  1  one-cycle read pulse.
- read_data  out  DATA_BUS_WIDTH  read-back data.
- read_valid  out  1  high for one cycle, the cycle after read_request.
- outputs_idle  in  OUTPUT_COUNT  per-channel idle flag from the apa102_out instances.
- word_counts  out  16*OUTPUT_COUNT  active word counts; channel i at [16i+15:16i].
- start_addresses  out  16*OUTPUT_COUNT  active start addresses.
- clock_divisors  out  2*OUTPUT_COUNT  active clock divisors.
- page_counts  out  8*OUTPUT_COUNT  active page counts.
- double_pixels  out  OUTPUT_COUNT  active double-pixel flags.
- output_resets  out  OUTPUT_COUNT  active-high channel resets.
- busy  out  1  high while a commit is in progress.

Behaviour:
- Register map (offset = address[3:0], block = address[15:4] - REG_BASE):
  - Blocks 0, 1, 3, 4: per-channel word_count, start_address, clock_divisor[1:0], page_count[7:0], indexed by offset. Offset ≥ OUTPUT_COUNT: write ignored, reads return 0.
  - Block 2: offset 0 is the shared manual reset mask (bits [OUTPUT_COUNT-1:0]).
  - Block 5: offset 0 is the shared double_pixel mask.
  - Block 6: offset 0 is control. Bit 0 = commit (self-clearing). Bit 1 = wait_idle mode, stored.
  - Block 7: offset 0 is status, read-only: {13'b0, overrun, dirty, busy}.
  - Any other block: writes ignored, reads return 0.
- Reset (rst low, async): all shadow and active registers go to 0 except page_counts = 1. Manual reset mask = all 1s, so output_resets is all 1s. FSM goes to IDLE. read_valid = 0, read_data = 0, busy = 0, dirty = 0, overrun = 0, wait_idle = 0.
- Shadow write: one cycle after write_strobe the shadow register is updated and dirty is set. Manual reset mask and wait_idle take effect immediately; they are not shadowed.
- output_resets[i] = manual_mask[i] OR hold_active[i].
- FSM states: IDLE, WAIT_IDLE, APPLY, HOLD.
  - IDLE: a commit write goes to WAIT_IDLE if wait_idle = 1, otherwise to APPLY.
  - WAIT_IDLE: stays until outputs_idle is all 1s, then goes to APPLY. No timeout.
  - APPLY (exactly 1 cycle):
    - Active registers are loaded from shadow.
    - changed[i] is set when any field of channel i differs between shadow and the old active value.
    - hold_active is loaded with changed. The hold counter is loaded with RESET_HOLD_CYCLES-1. dirty is cleared.
    - Next state is HOLD if changed != 0, otherwise IDLE.
  - HOLD: the counter decrements each cycle. At 0, hold_active is cleared and the FSM returns to IDLE. A changed channel's reset is therefore high for exactly RESET_HOLD_CYCLES cycles, starting the cycle after APPLY.
- busy = (state != IDLE).
- Commit write while busy: ignored and overrun is set.
- overrun clears on the cycle after a status read (read_request to block 7).
- Shadow write in the same cycle as APPLY: APPLY copies the pre-write shadow value. The write lands in shadow and dirty stays set.
- Shadow writes during WAIT_IDLE and HOLD are allowed and are not applied until the next commit.
- Read-back: read_data is registered. It returns the shadow value (fields zero-extended to DATA_BUS_WIDTH), or status for block 7. read_data holds its value until the next read. Simultaneous read and write to the same register returns the pre-write value.
- A write and a read on the same cycle are both serviced; no stall.

Test Plan:
- Reset then release: output_resets = all 1s, page_counts = 1 on every channel, busy = 0; read status → 0x0000 with read_valid exactly one cycle after read_request.
- Write word_count[2] = 0x0123 and commit with wait_idle = 0:
  - word_counts[47:32] updates the cycle after APPLY.
  - Only output_resets[2] is high (manual mask cleared beforehand), for exactly RESET_HOLD_CYCLES = 16 cycles.
  - busy falls when the reset pulse ends.
- Set wait_idle = 1 and hold outputs_idle = 0b1111111110, then commit:
  - The FSM stays in WAIT_IDLE and actives do not change for 100 cycles.
  - Raise bit 0 → APPLY runs on the next cycle.
- Issue a commit during HOLD: it is ignored and status reads 0x0005 (overrun and busy; the commit itself does not set dirty). The next status read returns overrun = 0.
- Write to offset 12 with OUTPUT_COUNT = 10, and to block REG_BASE+8: no register changes and dirty stays 0. Read of either returns 0.
- Assert rst mid-HOLD: all outputs are at reset values on the same cycle (asynchronous); after release, busy = 0 and actives are at reset values.
